ipf_lcu_feeder: RTL and testbench
=================================

IPF_LCU_FEEDER -- requirements
Module: ipf_lcu_feeder

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle cycles inserted after the last pixel of each LCU (range 1..15).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins one 128x128 image transfer.
REQ-005 cfg_lcu_size  input  2  0=16, 1=32, 2 or 3=64; sampled on accepted start.
REQ-006 img_rd  output  1  image memory read strobe.
REQ-007 img_addr  output  14  raster address row*128+col; read data returns one cycle later.
REQ-008 img_q  input  8  image read data, valid the cycle after img_rd.
REQ-009 par_addr  output  6  LCU parameter table index, lcu_y*N+lcu_x (N=128/size).
REQ-010 par_q  input  24  {ipf_type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, valid one cycle after par_addr.
REQ-011 busy  input  1  filter back-pressure.
REQ-012 finish  input  1  filter end-of-image indication.
REQ-013 in_en, din  output  1, 8  pixel valid and pixel value.
REQ-014 ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset  output  2, 5, 1, 16  current LCU parameters.
REQ-015 lcu_x, lcu_y, lcu_size  output  3, 3, 2  current LCU position and latched size.
REQ-016 done  output  1  one-cycle pulse at end of transfer.

Function
REQ-017 States: IDLE, PREP, LOAD, STREAM, GAP, DRAIN, DONE.
REQ-018 IDLE->PREP on start; start outside IDLE ignored.
REQ-019 PREP: par_addr driven for the current LCU; next state LOAD.
REQ-020 LOAD: par_q registered onto the ipf_* outputs, lcu_x/lcu_y updated; next state STREAM.
REQ-021 STREAM: LCU pixels sent column-fastest, then row; img_addr = {lcu_y,row,lcu_x,col} packed per size as (lcu_y*size+row)*128+lcu_x*size+col.
REQ-022 img_rd issued only in cycles with busy=0; a read issued in cycle t yields in_en=1, din=img_q in cycle t+1, regardless of busy in t+1.
REQ-023 in_en=0 in every cycle not following an img_rd; the col/row counters advance only on an issued read.
REQ-024 After the read of pixel (size-1,size-1): state GAP for GAP_CYCLES cycles; ipf_*/lcu_x/lcu_y held stable through the last in_en and all GAP cycles.
REQ-025 GAP exit: next LCU (lcu_x wraps to 0 at N-1 and increments lcu_y) -> PREP; after the last LCU -> DRAIN.
REQ-026 DRAIN: wait until finish=1, then DONE; DONE asserts done for 1 cycle -> IDLE.
REQ-027 Throughput with busy=0: exactly size*size consecutive in_en cycles per LCU; per-LCU overhead = GAP_CYCLES+2 cycles.
REQ-028 Simultaneous busy rise and last-pixel read: the read is withheld; the last pixel is sent after busy falls.

Reset
REQ-029 Reset forces IDLE; all outputs 0 (in_en, img_rd, done, din, addresses, ipf_*, lcu_*).
REQ-030 Reset mid-transfer aborts without done; any in-flight read data is discarded.

Structure
REQ-031 Shared package ipf_pkg: state encoding, size decode (end index 15/31/63), par_q field offsets, image width 128.
REQ-032 One sub-module, ipf_lcu_addr_gen: col/row/lcu_x/lcu_y counters and img_addr/par_addr packing.

Verification
REQ-033 size=16, busy=0, ramp image img[a]=a[7:0]: 64 LCUs; first LCU din=0..15 on row 0, then 128..143 on row 1 as img_addr; 16384 in_en total; done 1 cycle after finish.
REQ-034 size=64, par table entries distinct: ipf_* change only in LOAD, 4 LCUs in order (0,0),(1,0),(0,1),(1,1); no change during in_en or GAP.
REQ-035 size=32, busy high for 5 cycles mid-row: exactly 1 in_en after busy rises, no duplicate or skipped pixel, address continuity preserved.
REQ-036 Reset asserted during the 3rd LCU: next cycle all outputs 0; a new start restarts at lcu (0,0), pixel address 0.
REQ-037 start pulsed during STREAM: ignored; finish withheld 20 cycles: state remains DRAIN, done only after finish.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared definitions for the LCU feeder: FSM encoding, LCU size decode,
// parameter-word layout and image geometry.
package ipf_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_AW = 14;
  localparam int PAR_W  = 24;

  localparam int PAR_TYPE_LSB = 22;
  localparam int PAR_BAND_LSB = 17;
  localparam int PAR_WO_BIT   = 16;
  localparam int PAR_OFF_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } ipf_state_e;

  typedef enum logic [1:0] {
    SZ_16 = 2'd0,
    SZ_32 = 2'd1,
    SZ_64 = 2'd2
  } lcu_sz_e;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  band_pos;
    logic        wo_class;
    logic [15:0] offset;
  } ipf_par_t;

  // Codes 2 and 3 both select 64x64.
  function automatic lcu_sz_e sz_decode(input logic [1:0] cfg);
    case (cfg)
      2'd0:    return SZ_16;
      2'd1:    return SZ_32;
      default: return SZ_64;
    endcase
  endfunction

  function automatic logic [5:0] sz_end(input lcu_sz_e sz);
    case (sz)
      SZ_16:   return 6'd15;
      SZ_32:   return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

  function automatic logic [2:0] lcu_last(input lcu_sz_e sz);
    case (sz)
      SZ_16:   return 3'd7;
      SZ_32:   return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  function automatic ipf_par_t par_unpack(input logic [PAR_W-1:0] q);
    ipf_par_t p;
    p.typ      = q[PAR_TYPE_LSB +: 2];
    p.band_pos = q[PAR_BAND_LSB +: 5];
    p.wo_class = q[PAR_WO_BIT];
    p.offset   = q[PAR_OFF_LSB +: 16];
    return p;
  endfunction

endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// Pixel (col/row) and LCU (x/y) counters with raster image-address and
// parameter-table index packing for the selected LCU size.
module ipf_lcu_addr_gen
  import ipf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              pix_adv,
  input  logic              lcu_adv,
  input  lcu_sz_e           sz,
  output logic [2:0]        cnt_x,
  output logic [2:0]        cnt_y,
  output logic              last_pix,
  output logic              last_lcu,
  output logic [IMG_AW-1:0] img_addr,
  output logic [5:0]        par_addr
);

  logic [5:0] col_q, col_d, row_q, row_d;
  logic [2:0] x_q, x_d, y_q, y_d;
  logic [6:0] img_row, img_col;

  assign last_pix = (col_q == sz_end(sz)) && (row_q == sz_end(sz));
  assign last_lcu = (x_q == lcu_last(sz)) && (y_q == lcu_last(sz));
  assign cnt_x    = x_q;
  assign cnt_y    = y_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else begin
      if (pix_adv) begin
        if (col_q == sz_end(sz)) begin
          col_d = '0;
          row_d = (row_q == sz_end(sz)) ? 6'd0 : row_q + 6'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      if (lcu_adv) begin
        if (x_q == lcu_last(sz)) begin
          x_d = '0;
          y_d = (y_q == lcu_last(sz)) ? 3'd0 : y_q + 3'd1;
        end else begin
          x_d = x_q + 3'd1;
        end
      end
    end
  end

  // Size is a power of two, so the multiply-add collapses into bit concatenation.
  always_comb begin
    case (sz)
      SZ_16: begin
        img_row  = {y_q, row_q[3:0]};
        img_col  = {x_q, col_q[3:0]};
        par_addr = {y_q, x_q};
      end
      SZ_32: begin
        img_row  = {y_q[1:0], row_q[4:0]};
        img_col  = {x_q[1:0], col_q[4:0]};
        par_addr = {2'b00, y_q[1:0], x_q[1:0]};
      end
      default: begin
        img_row  = {y_q[0], row_q};
        img_col  = {x_q[0], col_q};
        par_addr = {4'b0000, y_q[0], x_q[0]};
      end
    endcase
    img_addr = {img_row, img_col};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 image to the in-loop filter one LCU at a time, loading
// each LCU's filter parameters before its pixels and idling between LCUs.
module ipf_lcu_feeder
  import ipf_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_lcu_size,
  output logic              img_rd,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [7:0]        img_q,
  output logic [5:0]        par_addr,
  input  logic [PAR_W-1:0]  par_q,
  input  logic              busy,
  input  logic              finish,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [1:0]        ipf_type,
  output logic [4:0]        ipf_band_pos,
  output logic              ipf_wo_class,
  output logic [15:0]       ipf_offset,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic              done
);

  ipf_state_e state_q, state_d;
  lcu_sz_e    sz_q, sz_d;
  ipf_par_t   ipf_q, ipf_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] lx_q, lx_d, ly_q, ly_d;
  logic       in_en_q, in_en_d, done_q, done_d;
  logic       ctr_clr, lcu_adv;
  logic [2:0] cnt_x, cnt_y;
  logic       last_pix, last_lcu;

  // The read strobe must react to busy in the same cycle, so it is the one
  // output decoded combinationally from state.
  assign img_rd = (state_q == ST_STREAM) && !busy;

  ipf_lcu_addr_gen u_addr (
    .clk      (clk),
    .reset    (reset),
    .clr      (ctr_clr),
    .pix_adv  (img_rd),
    .lcu_adv  (lcu_adv),
    .sz       (sz_q),
    .cnt_x    (cnt_x),
    .cnt_y    (cnt_y),
    .last_pix (last_pix),
    .last_lcu (last_lcu),
    .img_addr (img_addr),
    .par_addr (par_addr)
  );

  always_comb begin
    state_d = state_q;
    sz_d    = sz_q;
    ipf_d   = ipf_q;
    gap_d   = gap_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    in_en_d = img_rd;
    done_d  = 1'b0;
    ctr_clr = 1'b0;
    lcu_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sz_d    = sz_decode(cfg_lcu_size);
          ctr_clr = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: state_d = ST_LOAD;
      ST_LOAD: begin
        ipf_d   = par_unpack(par_q);
        lx_d    = cnt_x;
        ly_d    = cnt_y;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (img_rd && last_pix) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          if (last_lcu) begin
            state_d = ST_DRAIN;
          end else begin
            lcu_adv = 1'b1;
            state_d = ST_PREP;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (finish) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ctr_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sz_q    <= SZ_16;
      ipf_q   <= '0;
      gap_q   <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      in_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sz_q    <= sz_d;
      ipf_q   <= ipf_d;
      gap_q   <= gap_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      in_en_q <= in_en_d;
      done_q  <= done_d;
    end
  end

  // Read data arrives the cycle after the strobe, so it passes straight through.
  assign in_en        = in_en_q;
  assign din          = in_en_q ? img_q : 8'd0;
  assign ipf_type     = ipf_q.typ;
  assign ipf_band_pos = ipf_q.band_pos;
  assign ipf_wo_class = ipf_q.wo_class;
  assign ipf_offset   = ipf_q.offset;
  assign lcu_x        = lx_q;
  assign lcu_y        = ly_q;
  assign lcu_size     = sz_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed scoreboard bench for ipf_lcu_feeder with ramp image and distinct
// parameter table models.
module tb_ipf_lcu_feeder;

  localparam int GAP = 2;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, busy = 1'b0, finish = 1'b0;
  logic [1:0]  cfg = 2'd0;
  logic        img_rd, in_en, done, ipf_wo_class;
  logic [13:0] img_addr;
  logic [7:0]  img_q, din;
  logic [5:0]  par_addr;
  logic [23:0] par_q;
  logic [1:0]  ipf_type, lcu_size;
  logic [4:0]  ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;

  ipf_lcu_feeder #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg),
    .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
    .par_addr(par_addr), .par_q(par_q), .busy(busy), .finish(finish),
    .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
    .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
    .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] par_fn(input int idx);
    logic [5:0] a;
    a = idx[5:0];
    return {a[1:0], a[4:0] ^ 5'h15, ~a[0], 4'hC, a, a};
  endfunction

  always @(posedge clk) begin
    if (img_rd) img_q <= img_addr[7:0];
    par_q <= par_fn(int'(par_addr));
  end

  int n_assert = 0, n_fail = 0;
  logic [13:0] sb[$];
  int cur_sz = 16, cur_code = 0;
  int pix_cnt = 0, done_cnt = 0, chg_cnt = 0;
  int run_len = 0, gap_len = 0;
  bit seen_run = 0, thru_on = 0;
  logic cap_rd, cap_rst;
  logic [13:0] cap_addr;
  logic [23:0] prev_ipf = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [13:0] e;
    logic [23:0] cur_ipf;
    int lx, ly, sh;
    @(negedge clk);
    cap_rd = img_rd; cap_addr = img_addr; cap_rst = reset;
    @(posedge clk); #1;
    chk("in_en_follows_rd", in_en, cap_rd && !cap_rst);
    if (in_en === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", in_en, 0);
      else begin
        e = sb.pop_front();
        pix_cnt++;
        sh = (cur_sz == 16) ? 4 : (cur_sz == 32) ? 5 : 6;
        lx = int'(e[6:0]) >> sh;
        ly = int'(e[13:7]) >> sh;
        chk("pix_addr", cap_addr, e);
        chk("din", din, e[7:0]);
        chk("lcu_x", lcu_x, lx);
        chk("lcu_y", lcu_y, ly);
        chk("ipf_bundle", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset},
            par_fn(ly * (128 / cur_sz) + lx));
        chk("lcu_size", lcu_size, cur_code);
      end
    end
    if (thru_on) begin
      if (in_en === 1'b1) begin
        if (run_len == 0 && seen_run) chk("lcu_overhead", gap_len, GAP + 2);
        run_len++; gap_len = 0;
      end else begin
        if (run_len > 0) begin chk("lcu_run_len", run_len, cur_sz * cur_sz); seen_run = 1; end
        run_len = 0; gap_len++;
      end
    end
    if (done === 1'b1) done_cnt++;
    cur_ipf = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
    if (cur_ipf !== prev_ipf) chg_cnt++;
    prev_ipf = cur_ipf;
  endtask

  task automatic start_run(input int code, input int sz);
    int n;
    n = 128 / sz;
    cur_sz = sz; cur_code = code;
    for (int ly = 0; ly < n; ly++)
      for (int lx = 0; lx < n; lx++)
        for (int r = 0; r < sz; r++)
          for (int c = 0; c < sz; c++)
            sb.push_back(14'((ly * sz + r) * 128 + lx * sz + c));
    cfg = 2'(code); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain_pixels(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin tick(); k++; end
    chk("pixels_left_after_budget", sb.size(), 0);
  endtask

  task automatic finish_seq(input int hold);
    repeat (hold) begin tick(); chk("done_before_finish", done, 0); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("done_after_finish", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic wait_pix(input int target, input int budget);
    int k;
    k = 0;
    while (pix_cnt < target && k < budget) begin tick(); k++; end
    chk("pix_target_reached", pix_cnt >= target, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_en"}, in_en, 0);
    chk({tag, "_img_rd"}, img_rd, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_img_addr"}, img_addr, 0);
    chk({tag, "_par_addr"}, par_addr, 0);
    chk({tag, "_ipf"}, {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, 0);
    chk({tag, "_lcu_xy"}, {lcu_x, lcu_y}, 0);
    chk({tag, "_lcu_size"}, lcu_size, 0);
  endtask

  initial begin
    int p0, d0, k;

    // Reset state.
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // 16x16 LCUs, no back-pressure: full image, throughput and done timing.
    pix_cnt = 0; thru_on = 1; seen_run = 0; run_len = 0; gap_len = 0;
    start_run(0, 16);
    drain_pixels(17000);
    thru_on = 0;
    chk("total_in_en_16", pix_cnt, 16384);
    finish_seq(4);
    chk("done_pulses_run16", done_cnt, 1);

    // 64x64 LCUs: parameter changes only per LCU, stray start ignored,
    // finish withheld while draining.
    pix_cnt = 0; chg_cnt = 0;
    prev_ipf = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
    start_run(2, 64);
    wait_pix(100, 500);
    cfg = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lcu_size_after_stray_start", lcu_size, 2);
    drain_pixels(17000);
    chk("ipf_changes_64", chg_cnt, 4);
    finish_seq(20);
    chk("done_pulses_run64", done_cnt, 2);

    // 32x32 LCUs: busy mid-row, then busy rising on the last pixel read.
    pix_cnt = 0;
    start_run(1, 32);
    wait_pix(40, 500);
    busy = 1'b1;
    chk("in_en_at_busy_rise", in_en, 1);
    p0 = pix_cnt;
    repeat (5) tick();
    chk("in_en_during_busy", pix_cnt - p0, 0);
    busy = 1'b0;
    k = 0;
    while (!(img_addr === 14'd3999 && img_rd === 1'b1) && k < 5000) begin tick(); k++; end
    chk("reached_last_pix", img_addr, 3999);
    busy = 1'b1;
    p0 = pix_cnt;
    repeat (3) tick();
    chk("last_pix_withheld", pix_cnt - p0, 0);
    chk("last_addr_held", img_addr, 3999);
    busy = 1'b0;
    drain_pixels(17000);
    chk("total_in_en_32", pix_cnt, 16384);
    finish_seq(4);

    // Reset during the third LCU, then restart from the origin.
    pix_cnt = 0;
    start_run(0, 16);
    wait_pix(2 * 256 + 10, 1500);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk_zero("abort");
    reset = 1'b0;
    sb.delete();
    repeat (3) tick();
    chk("no_done_on_abort", done_cnt, d0);
    pix_cnt = 0;
    start_run(0, 16);
    chk("restart_par_addr", par_addr, 0);
    chk("restart_img_addr", img_addr, 0);
    wait_pix(300, 1000);
    reset = 1'b1;
    tick();
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
